// File: rtl/apb_master_pkg.sv
// Shared encodings and default widths for the APB requester slice.
package apb_master_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TIMEOUT    = 16;
    // Wide enough for the largest legal TIMEOUT (255).
    localparam int CNT_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// APB bus between one requester and one completer.
interface apb_master_if
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    // A transfer completes on the first ACCESS cycle that samples pready=1;
    // paddr/pwrite/pwdata stay stable from SETUP until that cycle.
    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS wait cycles; expired flags the last cycle allowed before abort.
module apb_timeout_cnt
    import apb_master_pkg::*;
(
    input  logic                 pclk,
    input  logic                 prst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] count;

    assign expired = (count == limit - 1'b1);

    // Holding at the limit keeps the count from wrapping if en lingers.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: command in, APB SETUP/ACCESS out, one-cycle response pulse.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  pclk,
    input  logic                  prst_n,
    // Command channel: a command transfers on a cycle with cmd_valid && cmd_ready.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    apb_master_if.master          apb,
    output apb_state_e            state_dbg
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT);

    apb_state_e state_q, state_d;

    logic                  accept;
    logic                  done_ok;
    logic                  done_to;
    logic                  cnt_expired;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign state_dbg = state_q;

    apb_timeout_cnt u_timeout_cnt (
        .pclk    (pclk),
        .prst_n  (prst_n),
        .clr     (accept),
        .en      ((state_q == ACCESS) && !apb.pready),
        .limit   (LIMIT),
        .expired (cnt_expired)
    );

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pready is checked before the counter so a ready on the limit cycle completes.
    always_comb begin
        state_d = IDLE;
        done_ok = 1'b0;
        done_to = 1'b0;
        case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (apb.pready) begin
                    done_ok = 1'b1;
                end else if (cnt_expired) begin
                    done_to = 1'b1;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every bus and response output comes straight from a flop.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            psel_q      <= (state_d != IDLE);
            penable_q   <= (state_d == ACCESS);
            rsp_valid_q <= done_ok || done_to;
            if (accept) begin
                pwrite_q <= cmd_write;
                paddr_q  <= cmd_addr;
                pwdata_q <= cmd_write ? cmd_wdata : '0;
            end
            if (done_ok) begin
                rsp_rdata_q   <= pwrite_q ? '0 : apb.prdata;
                rsp_err_q     <= apb.pslverr;
                rsp_timeout_q <= 1'b0;
            end else if (done_to) begin
                rsp_rdata_q   <= '0;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: random commands, scripted completer, scoreboard of expected responses.
`timescale 1ns/1ps
module tb_apb_master;
    import apb_master_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;
    // Expected-entry layout, LSB first: acc[8] | timeout | err | rdata | pwdata | pwrite | addr
    localparam int TO_B   = 8;
    localparam int ERR_B  = 9;
    localparam int RD_LSB = 10;
    localparam int WD_LSB = 10 + DW;
    localparam int WR_B   = 10 + 2 * DW;
    localparam int AD_LSB = 11 + 2 * DW;
    localparam int EW     = AW + 11 + 2 * DW;

    // ---------------- clock / reset ----------------
    logic pclk   = 1'b0;
    logic prst_n = 1'b0;
    always #5 pclk = ~pclk;

    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    apb_state_e    state_dbg;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .pclk        (pclk),
        .prst_n      (prst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (apb),
        .state_dbg   (state_dbg)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [EW-1:0] exp_q[$];
    int            cur_waits = 0;
    logic          cur_err   = 1'b0;
    logic [DW-1:0] cur_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psel"},        apb.psel,    0);
        check({tag, "_penable"},     apb.penable, 0);
        check({tag, "_pwrite"},      apb.pwrite,  0);
        check({tag, "_paddr"},       apb.paddr,   0);
        check({tag, "_pwdata"},      apb.pwdata,  0);
        check({tag, "_rsp_valid"},   rsp_valid,   0);
        check({tag, "_rsp_rdata"},   rsp_rdata,   0);
        check({tag, "_rsp_err"},     rsp_err,     0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_state"},       state_dbg,   IDLE);
    endtask

    // ---------------- completer: pready on ACCESS cycle waits+1, junk otherwise ----------------
    initial begin : completer
        int acc_seen;
        acc_seen    = 0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        forever begin
            @(negedge pclk);
            if (apb.psel && apb.penable) begin
                apb.pready = (acc_seen == cur_waits);
                acc_seen++;
            end else if (apb.psel) begin
                apb.pready = 1'($urandom_range(0, 1));
                acc_seen   = 0;
            end else begin
                apb.pready = 1'b0;
                acc_seen   = 0;
            end
            apb.pslverr = apb.pready ? cur_err : 1'($urandom_range(0, 1));
            apb.prdata  = apb.pready ? cur_rdata : DW'($urandom);
        end
    end

    // ---------------- driver ----------------
    // Reference: a transfer whose completer needs `waits` wait states takes waits+1
    // ACCESS cycles unless that exceeds TO, in which case it aborts after TO cycles.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic err, input logic [DW-1:0] rd, input bit hold);
        int            guard;
        int            acc;
        logic          timed_out;
        logic [DW-1:0] e_wd;
        logic [DW-1:0] e_rd;
        logic          e_err;
        guard = 0;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && guard < 100) begin
            @(negedge pclk);
            guard++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        cur_waits = waits;
        cur_err   = err;
        cur_rdata = rd;
        timed_out = (waits >= TO);
        acc       = timed_out ? TO : waits + 1;
        e_wd      = w ? d : '0;
        e_rd      = (w || timed_out) ? '0 : rd;
        e_err     = timed_out ? 1'b1 : err;
        exp_q.push_back({a, w, e_wd, e_rd, e_err, timed_out, 8'(acc)});
        @(posedge pclk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge pclk);
            guard++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int            m_psel;
        int            m_acc;
        logic [EW-1:0] h;
        logic [DW-1:0] last_rdata;
        logic          last_err;
        logic          last_to;
        m_psel = 0;
        m_acc  = 0;
        last_rdata = '0;
        last_err   = 1'b0;
        last_to    = 1'b0;
        forever begin
            @(negedge pclk);
            if (!prst_n) begin
                m_psel = 0;
                m_acc  = 0;
                last_rdata = '0;
                last_err   = 1'b0;
                last_to    = 1'b0;
            end else begin
                if (apb.psel) begin
                    check("cmd_ready_busy", cmd_ready, 0);
                    check("penable_phase", apb.penable, (m_psel > 0));
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL apb_unexpected: psel=1 with no command pending at %0t", $time);
                    end else begin
                        h = exp_q[0];
                        check("paddr_stable",  apb.paddr,  h[AD_LSB +: AW]);
                        check("pwrite_stable", apb.pwrite, h[WR_B]);
                        check("pwdata_stable", apb.pwdata, h[WD_LSB +: DW]);
                    end
                    m_psel++;
                    if (apb.penable) m_acc++;
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rsp_spurious: rsp_valid=1 with nothing expected at %0t", $time);
                    end else begin
                        h = exp_q.pop_front();
                        check("rsp_rdata",     rsp_rdata,   h[RD_LSB +: DW]);
                        check("rsp_err",       rsp_err,     h[ERR_B]);
                        check("rsp_timeout",   rsp_timeout, h[TO_B]);
                        check("access_cycles", m_acc,       h[7:0]);
                        check("psel_cycles",   m_psel,      h[7:0] + 1);
                        check("psel_after",    apb.psel,    0);
                        check("penable_after", apb.penable, 0);
                    end
                    m_psel = 0;
                    m_acc  = 0;
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                    last_to    = rsp_timeout;
                end else begin
                    check("rsp_hold_rdata",   rsp_rdata,   last_rdata);
                    check("rsp_hold_err",     rsp_err,     last_err);
                    check("rsp_hold_timeout", rsp_timeout, last_to);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int            guard;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
        logic          err;
        int            waits;
        bit            hold;

        #2;
        check_all_zero("reset");
        check("reset_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        @(negedge pclk);
        #2 prst_n = 1'b1;

        // Write, zero wait states
        send(1'b1, 8'h03, 8'hA5, 0, 1'b0, 8'h77, 1'b0);
        drain();
        // Read with three wait states, ready lands on the timeout limit cycle
        send(1'b0, 8'h05, 8'h11, 3, 1'b0, 8'h3C, 1'b0);
        drain();
        // Read with slave error
        send(1'b0, 8'h09, 8'h00, 0, 1'b1, 8'hC3, 1'b0);
        drain();
        // Completer never ready: abort after TO ACCESS cycles
        send(1'b0, 8'h0B, 8'h00, 50, 1'b0, 8'h99, 1'b0);
        drain();

        // Reset pulsed during ACCESS of a write
        send(1'b1, 8'h02, 8'h5A, 3, 1'b0, 8'h44, 1'b0);
        guard = 0;
        while (!(apb.psel && apb.penable) && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        check("reach_access", apb.penable, 1);
        #2 prst_n = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        @(negedge pclk);
        @(negedge pclk);
        #2 prst_n = 1'b1;
        repeat (3) @(negedge pclk);
        send(1'b0, 8'h02, 8'h00, 1, 1'b0, 8'hE7, 1'b0);
        drain();

        // Back-to-back with cmd_valid held high
        send(1'b1, 8'h10, 8'h01, 0, 1'b0, 8'h00, 1'b1);
        send(1'b0, 8'h11, 8'h02, 2, 1'b0, 8'h5F, 1'b1);
        send(1'b1, 8'h12, 8'h03, 9, 1'b0, 8'h00, 1'b1);
        send(1'b0, 8'h13, 8'h04, 0, 1'b1, 8'hAA, 1'b0);
        drain();

        // Randomized traffic
        repeat (40) begin
            w     = 1'($urandom_range(0, 1));
            a     = AW'($urandom);
            d     = DW'($urandom);
            rd    = DW'($urandom);
            err   = ($urandom_range(0, 3) == 0);
            waits = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, TO - 1);
            hold  = 1'($urandom_range(0, 1));
            send(w, a, d, waits, err, rd, hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge pclk);
        end
        cmd_valid = 1'b0;
        drain();
        repeat (4) @(negedge pclk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
